wb_sram32: RTL

Wishbone slave bridging the LM32 data/instruction bus to two external 16-bit asynchronous SRAMs forming one 32-bit word. One access per Wishbone cycle, a fixed number of wait states, byte-lane writes via the SRAM byte enables. Sits inside `system` between the Wishbone interconnect and the board SRAM pins, and is exercised in simulation against two `sram16` models.

---
 rtl/wb_sram_pkg.sv | 15 +
 rtl/wb_sram32.sv | 137 +++++++++++++
 2 files changed

// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-asynchronous-SRAM bridge.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_HOLD
    } state_t;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;

endpackage

// File: rtl/wb_sram32.sv
// Wishbone slave driving two 16-bit asynchronous SRAMs as one 32-bit word,
// with a fixed number of access cycles and byte-lane writes.
module wb_sram32
    import wb_sram_pkg::*;
#(
    parameter int unsigned adr_width = 18,
    parameter int unsigned latency   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [adr_width-1:0] sram_adr,
    inout  wire  [31:0]          sram_dat,
    output logic [3:0]           sram_be_n,
    output logic [1:0]           sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
);

    if (latency < LATENCY_MIN || latency > LATENCY_MAX) begin : g_latency_check
        $error("wb_sram32: latency must lie in 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_abort;
    logic                   r_ack;
    logic [31:0]            r_dat;
    logic [adr_width-1:0]   r_adr;
    logic [31:0]            r_wdat;
    logic                   r_drive;
    logic [3:0]             r_be_n;
    logic [1:0]             r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;

    logic                   w_req;
    logic [adr_width-1:0]   w_adr;
    logic                   w_unused_adr;

    // Holding off while ack is high stops a master's stale strobe from
    // starting a second access in the cycle it sees the acknowledge.
    assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_adr        = wb_adr_i[adr_width+1:2];
    assign w_unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_drive <= 1'b0;
            r_be_n  <= '1;
            r_ce_n  <= '1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_adr   <= w_adr;
                        r_cnt   <= CNT_LOAD;
                        r_ce_n  <= '0;
                        r_abort <= 1'b0;
                        if (wb_we_i) begin
                            r_state <= ST_WRITE;
                            r_we_n  <= 1'b0;
                            r_be_n  <= ~wb_sel_i;
                            r_wdat  <= wb_dat_i;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                            r_oe_n  <= 1'b0;
                            r_be_n  <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        if (wb_cyc_i && !r_abort) begin
                            r_dat <= sram_dat;
                            r_ack <= 1'b1;
                        end
                        r_oe_n  <= 1'b1;
                        r_ce_n  <= '1;
                        r_be_n  <= '1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (!wb_cyc_i) r_abort <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == '0) begin
                        if (wb_cyc_i && !r_abort) r_ack <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (!wb_cyc_i) r_abort <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_drive <= 1'b0;
                    r_ce_n  <= '1;
                    r_be_n  <= '1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sram_dat  = r_drive ? r_wdat : 'z;
    assign wb_dat_o  = r_dat;
    assign wb_ack_o  = r_ack;
    assign sram_adr  = r_adr;
    assign sram_be_n = r_be_n;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;

endmodule
